// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer in front of a single-port data memory
module dmem_arbiter #(
  parameter int LATENCY = 2,
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        MemWrite_o,
  output logic        MemRead_o,
  output logic [31:0] Addr_o,
  output logic [31:0] WriteData_o,
  input  logic [31:0] ReadData_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  state_t state;
  logic last_grant;
  logic id;
  logic [CW-1:0] cnt;
  logic gnt;
  logic sel_we;
  logic bad;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  // pick the winner (alternate on a tie) and check its address before touching memory
  always_comb begin
    gnt = (req0_i && req1_i) ? ~last_grant : req1_i;
    sel_we = gnt ? we1_i : we0_i;
    sel_addr = gnt ? addr1_i : addr0_i;
    sel_wdata = gnt ? wdata1_i : wdata0_i;
    bad = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= DEPTH_W);
  end
  // sequencing FSM; done is raised on entry to DONE so it lasts exactly the DONE cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id <= 1'b0;
      cnt <= '0;
      done0_o <= 1'b0;
      done1_o <= 1'b0;
      err_o <= 1'b0;
      busy_o <= 1'b0;
      MemWrite_o <= 1'b0;
      MemRead_o <= 1'b0;
      rdata_o <= '0;
      Addr_o <= '0;
      WriteData_o <= '0;
    end else begin
      case (state)
        IDLE: if (req0_i || req1_i) begin
          last_grant <= gnt;
          id <= gnt;
          busy_o <= 1'b1;
          if (bad) begin
            state <= DONE;
            err_o <= 1'b1;
            done0_o <= ~gnt;
            done1_o <= gnt;
          end else begin
            state <= BUSY;
            cnt <= CW'(LATENCY - 1);
            Addr_o <= sel_addr;
            WriteData_o <= sel_wdata;
            MemWrite_o <= sel_we;
            MemRead_o <= ~sel_we;
          end
        end
        BUSY: if (cnt == '0) begin
          if (MemRead_o) rdata_o <= ReadData_i;
          MemWrite_o <= 1'b0;
          MemRead_o <= 1'b0;
          err_o <= 1'b0;
          done0_o <= ~id;
          done1_o <= id;
          state <= DONE;
        end else begin
          cnt <= cnt - CW'(1);
        end
        DONE: begin
          done0_o <= 1'b0;
          done1_o <= 1'b0;
          err_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
